// File: rtl/random_key_serializer.sv
// random_key_serializer: snapshots the 256-bit entropy buffer after SAMPLES_NEEDED fresh ready edges and streams it LSB-byte-first over valid/ack.
//   clock/reset_n (sync, active-low); ready: sample strobe (rising edges counted); buffer: entropy source;
//   key_request: start (IDLE only); key_byte/key_valid: registered byte stream; key_ack: consumer accept;
//   key_busy: not IDLE; key_done: one-cycle pulse after last ack.
//   KEY_FOLD_EN: when defined, each snapshot is XOR-folded into the previous key instead of replacing it.
module random_key_serializer #(
  parameter int SAMPLES_NEEDED = 32,
  parameter int COUNT_W = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ready,
  input  logic [255:0] buffer,
  input  logic         key_request,
  output logic [7:0]   key_byte,
  output logic         key_valid,
  input  logic         key_ack,
  output logic         key_busy,
  output logic         key_done
);
  typedef enum logic [2:0] {IDLE, GATHER, LATCH, SEND, DONE} state_t;
  localparam logic [COUNT_W-1:0] N = COUNT_W'(SAMPLES_NEEDED);
  state_t r_state, w_next;
  logic [COUNT_W-1:0] r_count;
  logic [4:0] r_idx;
  logic r_ready_q;
  logic [255:0] r_key;
  logic [255:0] w_snap;
  logic [4:0] w_nidx;
  logic w_edge, w_full, w_accept;
  assign w_edge = ready & ~r_ready_q;
  // The edge that brings the count to N moves straight to LATCH.
  assign w_full = w_edge && (r_count + 1'b1 == N);
  assign w_accept = (r_state == SEND) && key_valid && key_ack;
  assign w_nidx = r_idx + 5'd1;
`ifdef KEY_FOLD_EN
  assign w_snap = r_key ^ buffer;
`else
  assign w_snap = buffer;
`endif
  assign key_busy = r_state != IDLE;
  assign key_done = r_state == DONE;
  always_ff @(posedge clock)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = key_request ? GATHER : IDLE;
      GATHER:  w_next = w_full ? LATCH : GATHER;
      LATCH:   w_next = SEND;
      SEND:    w_next = (w_accept && r_idx == 5'd31) ? DONE : SEND;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ready_q <= 1'b0;
      r_count   <= '0;
      r_idx     <= '0;
      r_key     <= '0;
      key_byte  <= '0;
      key_valid <= 1'b0;
    end else begin
      r_ready_q <= ready;
      if (r_state == IDLE && key_request) r_count <= '0;
      else if (r_state == GATHER && w_edge && r_count != N) r_count <= r_count + 1'b1;
      if (r_state == LATCH) begin
        r_key     <= w_snap;
        r_idx     <= '0;
        key_byte  <= w_snap[7:0];
        key_valid <= 1'b1;
      end else if (w_accept) begin
        r_idx     <= w_nidx;
        key_byte  <= r_key[{w_nidx, 3'b000} +: 8];
        key_valid <= r_idx != 5'd31;
      end
    end
  end
endmodule

// File: tb/tb_random_key_serializer.sv
// tb_random_key_serializer: scoreboard bench with a byte-queue reference model for random_key_serializer.
module tb_random_key_serializer;
`ifdef KEY_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif
  logic clock = 0, reset_n = 0, ready = 0, key_request = 0, key_ack = 0;
  logic [255:0] buffer = '0;
  logic [7:0] key_byte;
  logic key_valid, key_busy, key_done;
  int compared = 0, mismatched = 0;
  logic [8:0] sb[$];
  logic [255:0] ref_key = '0;
  logic exp_done = 0;
  always #5 clock = ~clock;
  random_key_serializer #(.SAMPLES_NEEDED(4), .COUNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .ready(ready), .buffer(buffer),
    .key_request(key_request), .key_byte(key_byte), .key_valid(key_valid),
    .key_ack(key_ack), .key_busy(key_busy), .key_done(key_done)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    if (!reset_n) exp_done = 0;
    else begin
      chk("key_done", key_done, exp_done);
      exp_done = 0;
      if (key_valid) begin
        if (sb.size() == 0) chk("unexpected_byte", 1, 0);
        else begin
          chk("key_byte", key_byte, sb[0][7:0]);
          if (key_ack) begin
            exp_done = sb[0][8];
            void'(sb.pop_front());
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [255:0] rand_buf();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction
  task automatic request(input logic [255:0] b);
    chk("busy_before_req", key_busy, 0);
    buffer = b;
    ref_key = FOLD ? (ref_key ^ b) : b;
    for (int i = 0; i < 32; i++) sb.push_back({i == 31, ref_key[8*i +: 8]});
    key_request = 1;
    tick();
    key_request = 0;
    chk("busy_after_req", key_busy, 1);
  endtask
  task automatic gather(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      chk("no_valid_in_gather", key_valid, 0);
      ready = 1;
      if (k == n - 1) begin
        tick();
        chk("valid_in_latch", key_valid, 0);
        tick();
        chk("valid_after_latch", key_valid, 1);
        ready = 0;
      end else begin
        repeat (hi) tick();
        ready = 0;
        repeat (lo) tick();
      end
    end
  endtask
  task automatic stream(input int mode, output int c);
    for (c = 0; c < 600; c++) begin
      if (key_done) break;
      key_ack = mode == 0 || mode == 4 ? 1'b1 : mode == 1 ? c[0] : 1'($urandom_range(0, 1));
      key_request = mode == 4 && c == 5;
      if (mode == 4 && c == 6) chk("busy_ignored_req", key_busy, 1);
      tick();
    end
    key_ack = 0;
    key_request = 0;
  endtask
  task automatic finish_stream();
    chk("busy_in_done", key_busy, 1);
    tick();
    chk("busy_after_done", key_busy, 0);
    chk("done_one_cycle", key_done, 0);
  endtask
  initial begin
    int c;
    logic [255:0] b;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", key_valid, 0);
    chk("rst_busy", key_busy, 0);
    chk("rst_done", key_done, 0);
    chk("rst_byte", key_byte, 0);
    reset_n = 1;
    tick();
    for (int i = 0; i < 32; i++) b[8*i +: 8] = 8'(i + 1);
    request(b);
    gather(4, 3, 3);
    stream(0, c);
    chk("cycles_ack_held", c, 32);
    finish_stream();
    request(rand_buf());
    ready = 1;
    repeat (10) tick();
    chk("level_ready_no_latch", key_valid, 0);
    ready = 0;
    repeat (3) tick();
    gather(3, 3, 3);
    stream(0, c);
    chk("cycles_level", c, 32);
    finish_stream();
    request(rand_buf());
    gather(4, 2, 2);
    stream(1, c);
    chk("cycles_backpressure", c, 64);
    finish_stream();
    request(rand_buf());
    gather(4, 1, 1);
    stream(4, c);
    chk("cycles_ignored_req", c, 32);
    finish_stream();
    request(rand_buf());
    gather(4, 3, 3);
    for (int i = 0; i < 10; i++) begin
      key_ack = 1;
      tick();
    end
    reset_n = 0;
    key_ack = 0;
    tick();
    reset_n = 1;
    sb.delete();
    ref_key = '0;
    chk("rst_mid_valid", key_valid, 0);
    chk("rst_mid_busy", key_busy, 0);
    chk("rst_mid_byte", key_byte, 0);
    request({32{8'hA5}});
    gather(4, 3, 3);
    stream(0, c);
    chk("cycles_after_reset", c, 32);
    finish_stream();
    request({32{8'h0F}});
    gather(4, 3, 3);
    chk("fold_first_byte", key_byte, FOLD ? 8'hAA : 8'h0F);
    stream(0, c);
    finish_stream();
    repeat (6) begin
      ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) tick();
      ready = 0;
      tick();
      request(rand_buf());
      gather(4, $urandom_range(1, 4), $urandom_range(1, 4));
      stream(2, c);
      chk("random_done_reached", c < 600, 1);
      finish_stream();
    end
    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/random_key_serializer.md
# random_key_serializer

Downstream consumer of the 256-bit entropy buffer built from AC97 sample bytes. On request, it waits until enough fresh samples have been shifted into the buffer, snapshots the buffer as a 256-bit session key, and streams the key out one byte at a time over a valid/ack handshake to the phone's cipher/key-exchange logic. It watches the same `ready` strobe that drives the entropy buffer, so it knows how much fresh entropy has accumulated.

## Interface
- `SAMPLES_NEEDED`, default 32: rising edges of `ready` required after a request before the snapshot (32 × 8 bits = full buffer refresh).
- `COUNT_W`, default 6: sample-counter width; must hold `SAMPLES_NEEDED`.
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ready` in 1: sample strobe shared with the entropy buffer; may stay high for several cycles; only rising edges count.
- `buffer` in 256: entropy buffer contents.
- `key_request` in 1: start a key generation; sampled only in IDLE.
- `key_byte` out 8: current key byte.
- `key_valid` out 1: `key_byte` is valid.
- `key_ack` in 1: consumer accepts `key_byte` when high together with `key_valid`.
- `key_busy` out 1: high in every state except IDLE.
- `key_done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- Edge detect: `ready_q` register (resets to 0); an edge is `ready & ~ready_q`. If `ready` is high when reset deasserts, that counts as an edge.
- FSM states: IDLE, GATHER, LATCH, SEND, DONE.
- IDLE: `key_request`=1 → GATHER, sample count cleared to 0.
- GATHER: each edge increments the count. When the count equals `SAMPLES_NEEDED`, go to LATCH. The count saturates and never wraps. Edges outside GATHER are ignored.
- LATCH: `key_reg` ← `buffer`, byte index ← 0, then → SEND. LATCH lasts one cycle, which gives the buffer one cycle to absorb the final sample.
- SEND: `key_byte` = `key_reg[8*idx +: 8]`, least-significant byte first, with `key_valid`=1.
  - On `key_ack` with index < 31: index increments.
  - On `key_ack` with index = 31: → DONE.
  - `key_ack` while `key_valid`=0 is ignored.
- DONE: `key_done`=1 for one cycle, then → IDLE.
- `key_request` outside IDLE is ignored. Back-to-back requests are served after DONE.
- Reset values: state IDLE, count 0, index 0, `ready_q` 0, `key_reg` 0, `key_byte` 0, `key_valid` 0, `key_busy` 0, `key_done` 0.
- Reset mid-operation: all state returns to the reset values on the next edge and any partial key stream is abandoned. `key_reg` is cleared, including in KEY_FOLD mode.

## Timing
- `key_request` high in cycle t → GATHER and `key_busy`=1 from t+1.
- Count reaches `SAMPLES_NEEDED` at edge cycle e → LATCH at e+1, `key_valid`=1 from e+2.
- Ack is registered: the next byte appears the cycle after the ack. With `key_ack` held high, one byte per cycle, so 32 cycles for the stream.
- `key_done` asserts the cycle after the 32nd ack; `key_busy` drops the cycle after `key_done`.
- `key_byte` and `key_valid` are registered outputs.

## Configuration
- `KEY_FOLD_EN` defined: LATCH performs `key_reg` ← `key_reg ^ buffer`, so each key mixes all previous snapshots. `key_reg` is cleared only by reset.
- `KEY_FOLD_EN` undefined: LATCH performs a plain `key_reg` ← `buffer`.

## Test plan
- Basic stream (SAMPLES_NEEDED=4): drive `key_request` for 1 cycle, then 4 `ready` pulses, each high 3 cycles and low 3 cycles. Hold `buffer` with byte i = i+1. Hold `key_ack`=1. → `key_byte` sequence 0x01…0x20 on 32 consecutive cycles, then `key_done` for one cycle.
- Level `ready`: hold `ready` high for 10 cycles in GATHER → count = 1, no LATCH.
- Ack backpressure: toggle `key_ack` every other cycle → each byte is held stable until acked, no bytes skipped or repeated, and the stream takes 64 cycles.
- Ignored request: pulse `key_request` during SEND → no restart, stream completes normally, `key_busy` stays 1.
- Reset mid-SEND at byte 10: assert `reset_n`=0 for 1 cycle → `key_valid`=0, `key_busy`=0, and a new request restarts from GATHER with count 0.
- KEY_FOLD_EN: two requests with `buffer`=all 0xA5 then all 0x0F → second stream is all 0xAA. Without the macro, the second stream is all 0x0F.
